// File: rtl/bcd_tens_comp_serial.sv
// Digit-serial sign-magnitude BCD to ten's-complement converter, LSD first.
// Flags digits above 9 and normalises negative zero to a positive result.
module bcd_tens_comp_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_err,
  output logic                  busy
);

  localparam int DATA_W = 4 * DIGITS;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                carry;
  logic                err;
  logic                sign_r;
  logic [DATA_W-1:0]   bcd_r;
  logic [DATA_W-1:0]   res_r;
  logic [3:0]          dig;
  logic [4:0]          step;
  logic                last;
  logic                done;

  // One ten's-complement digit step: {carry_out, digit}. A sum of ten wraps
  // to zero and carries into the next digit.
  function automatic logic [4:0] neg_digit(input logic [3:0] d, input logic cin);
    logic [4:0] t;
    t = 5'd9 - {1'b0, d} + {4'b0000, cin};
    if (t == 5'd10) begin
      return 5'b1_0000;
    end
    return {1'b0, t[3:0]};
  endfunction

  always_comb begin
    dig  = bcd_r[int'(cnt)*4 +: 4];
    step = sign_r ? neg_digit(dig, carry) : {1'b0, dig};
    last = (cnt == CNT_W'(DIGITS - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid)  state_nxt = S_RUN;
      S_RUN:  if (last)      state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cnt   <= '0;
            carry <= 1'b1;
            err   <= 1'b0;
          end
        end
        S_RUN: begin
          cnt   <= last ? '0 : cnt + CNT_W'(1);
          carry <= step[4];
          if (dig > 4'd9) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand capture and result digits carry no reset; outputs are gated by state.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_valid) begin
      sign_r <= in_sign;
      bcd_r  <= in_bcd;
    end
    if (state == S_RUN) begin
      res_r[int'(cnt)*4 +: 4] <= step[3:0];
    end
  end

  always_comb begin
    done      = (state == S_DONE);
    in_ready  = (state == S_IDLE);
    busy      = (state != S_IDLE);
    out_valid = done;
    out_err   = done & err;
    out_bcd   = !done ? '0 : (err ? bcd_r : res_r);
    out_sign  = done & sign_r & (err | (res_r != '0));
  end

endmodule
